// File: rtl/lookahead_adder_4bit_m_pkg.sv
// Shared constants and result type for the 4-bit carry-lookahead adder.
package lookahead_adder_4bit_m_pkg;

  localparam int ADDER_W = 4;

  // Registered result: carry-out above the sum bits, so the packed value
  // reads directly as the 5-bit unsigned total.
  typedef struct packed {
    logic               carry;
    logic [ADDER_W-1:0] sum;
  } cla_result_t;

endpackage

// File: rtl/lookahead_adder_4bit_m_if.sv
// Operand/result bundle for the lookahead adder. grp_g/grp_p are the
// combinational group generate/propagate terms used to cascade 4-bit slices.
import lookahead_adder_4bit_m_pkg::*;

interface lookahead_adder_4bit_m_if;
  logic [ADDER_W-1:0] A;
  logic [ADDER_W-1:0] B;
  logic               C0;
  logic [ADDER_W-1:0] F;
  logic               C4;
  logic               grp_g;
  logic               grp_p;

  modport master (output A, B, C0, input F, C4, grp_g, grp_p);
  modport slave  (input A, B, C0, output F, C4, grp_g, grp_p);
endinterface

// File: rtl/lookahead_adder_4bit_m_cla_carry_unit_4.sv
// Flattened 4-bit lookahead carry unit: every carry is a two-level
// sum-of-products of g, p and c0, never of another computed carry.
import lookahead_adder_4bit_m_pkg::*;

module cla_carry_unit_4 (
  input  logic [ADDER_W-1:0] g,
  input  logic [ADDER_W-1:0] p,
  input  logic               c0,
  output logic [ADDER_W:1]   c,
  output logic               grp_g,
  output logic               grp_p
);

  assign c[1] = g[0] | (p[0] & c0);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c0);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);

  // Group terms let a second-level unit treat this slice as one bit.
  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);
  assign grp_p = p[3] & p[2] & p[1] & p[0];

endmodule

// File: rtl/lookahead_adder_4bit_m.sv
// Registered 4-bit carry-lookahead adder: {C4, F} = A + B + C0, one cycle later.
import lookahead_adder_4bit_m_pkg::*;

module lookahead_adder_4bit_m (
  input  logic                     clk,
  input  logic                     rst,
  lookahead_adder_4bit_m_if.slave  bus
);

  logic [ADDER_W-1:0] g;
  logic [ADDER_W-1:0] p;
  logic [ADDER_W-1:0] sum_next;
  logic [ADDER_W:1]   c_la;
  logic [ADDER_W:0]   carry;
  cla_result_t        result_next;
  cla_result_t        result_reg;

  // carry[0] is the external carry-in; the rest come from the lookahead unit.
  assign carry = {c_la, bus.C0};

  genvar gi;
  generate
    for (gi = 0; gi < ADDER_W; gi++) begin : g_bit
      assign g[gi]        = bus.A[gi] & bus.B[gi];
      assign p[gi]        = bus.A[gi] ^ bus.B[gi];
      assign sum_next[gi] = p[gi] ^ carry[gi];
    end
  endgenerate

  cla_carry_unit_4 u_carry (
    .g     (g),
    .p     (p),
    .c0    (bus.C0),
    .c     (c_la),
    .grp_g (bus.grp_g),
    .grp_p (bus.grp_p)
  );

  assign result_next.carry = carry[ADDER_W];
  assign result_next.sum   = sum_next;

  // Output register; reset wins over the data path and drops any pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_reg <= '0;
    end else begin
      result_reg <= result_next;
    end
  end

  assign bus.F  = result_reg.sum;
  assign bus.C4 = result_reg.carry;

endmodule

// File: tb/tb_lookahead_adder_4bit_m.sv
// Directed, exhaustive, latency and reset checks for lookahead_adder_4bit_m.
module tb_lookahead_adder_4bit_m;

  typedef struct {
    string      name;
    logic [3:0] a;
    logic [3:0] b;
    logic       c0;
    logic [3:0] f;
    logic       c4;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs[7];

  lookahead_adder_4bit_m_if bus ();

  lookahead_adder_4bit_m dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {C4,F}=%b required %b", name, got, exp);
    end else begin
      $display("ok   %s: {C4,F}=%b", name, got);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c0);
    bus.A  = a;
    bus.B  = b;
    bus.C0 = c0;
  endtask

  // Advance to one time unit past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] exp;
    logic [4:0] held;

    vecs[0] = '{"nocarry_4p3",    4'b0100, 4'b0011, 1'b0, 4'b0111, 1'b0};
    vecs[1] = '{"nocarry_3p2",    4'b0011, 4'b0010, 1'b0, 4'b0101, 1'b0};
    vecs[2] = '{"propagate_c0_0", 4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0};
    vecs[3] = '{"propagate_c0_1", 4'b1010, 4'b0101, 1'b1, 4'b0000, 1'b1};
    vecs[4] = '{"gen_12p7",       4'b1100, 4'b0111, 1'b0, 4'b0011, 1'b1};
    vecs[5] = '{"gen_15p15",      4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1};
    vecs[6] = '{"carryin_4p3p1",  4'b0100, 4'b0011, 1'b1, 4'b1000, 1'b0};

    // Reset with all-ones inputs must still clear the outputs.
    drive(4'b1111, 4'b1111, 1'b1);
    rst = 1'b1;
    step();
    check("reset_state", {bus.C4, bus.F}, 5'b00000);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].c0);
      step();
      check(vecs[i].name, {bus.C4, bus.F}, {vecs[i].c4, vecs[i].f});
    end

    // Exhaustive sweep, plus the combinational group terms for each input.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          drive(4'(a), 4'(b), 1'(c));
          #1;
          check($sformatf("grp_%0d_%0d", a, b), {3'b000, bus.grp_g, bus.grp_p},
                {3'b000, ((a + b) > 15) ? 1'b1 : 1'b0, ((a ^ b) == 15) ? 1'b1 : 1'b0});
          step();
          exp = 5'(a + b + c);
          check($sformatf("sum_%0d_%0d_%0d", a, b, c), {bus.C4, bus.F}, exp);
        end
      end
    end

    // Inputs changing between edges must not disturb the registered result.
    drive(4'b1001, 4'b0011, 1'b0);
    step();
    held = 5'd12;
    check("hold_load", {bus.C4, bus.F}, held);
    #1 drive(4'b1111, 4'b0001, 1'b1);
    #2 check("hold_midcycle", {bus.C4, bus.F}, held);
    @(negedge clk);
    check("hold_negedge", {bus.C4, bus.F}, held);
    step();
    check("hold_next_edge", {bus.C4, bus.F}, 5'd17);

    // Reset mid-stream clears, then the first edge after release loads new data.
    drive(4'b0111, 4'b0110, 1'b1);
    rst = 1'b1;
    step();
    check("midreset_zero", {bus.C4, bus.F}, 5'b00000);
    drive(4'b0010, 4'b0001, 1'b0);
    rst = 1'b0;
    step();
    check("after_release", {bus.C4, bus.F}, 5'd3);
    drive(4'b1000, 4'b1000, 1'b1);
    step();
    check("after_release_2", {bus.C4, bus.F}, 5'd17);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
